// File: rtl/video_pkg.sv
// Shared types for the video test-pattern generator.
// Mode and direction encodings plus the colour-bar lookup.
package video_pkg;

  typedef enum logic [2:0] {
    MODE_SOLID   = 3'd0,
    MODE_CROSS   = 3'd1,
    MODE_BLOCK   = 3'd2,
    MODE_BARS    = 3'd3,
    MODE_CHECKER = 3'd4
  } mode_e;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_e;

  // {R,G,B} enables: white, yellow, cyan, green, magenta, red, blue, black
  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    logic [2:0] c;
    case (idx)
      3'd0:    c = 3'b111;
      3'd1:    c = 3'b110;
      3'd2:    c = 3'b011;
      3'd3:    c = 3'b010;
      3'd4:    c = 3'b101;
      3'd5:    c = 3'b100;
      3'd6:    c = 3'b001;
      default: c = 3'b000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_pattern_gen_frame_tick.sv
// Frame-end detect on the VDE falling edge of the last row,
// plus the frame divider that paces the animation steps.
module frame_tick_gen #(
  parameter int V_ACTIVE  = 480,
  parameter int COORD_W   = 10,
  parameter int FRAME_DIV = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vde,
  input  logic [COORD_W-1:0] y,
  output logic               vde_d,
  output logic               frame_tick,
  output logic               step
);

  localparam int FCNT_W =
    (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [FCNT_W-1:0] FCNT_LAST =
    FCNT_W'(FRAME_DIV - 1);
  localparam logic [COORD_W-1:0] LAST_ROW =
    COORD_W'(V_ACTIVE - 1);

  logic               r_vde_d;
  logic [COORD_W-1:0] r_prev_row;
  logic [FCNT_W-1:0]  r_fcnt;
  logic               frame_end;
  logic               fcnt_wrap;

  // Only the line end of the final row counts, not every hblank
  assign frame_end = r_vde_d & ~vde &
                     (r_prev_row == LAST_ROW);
  assign fcnt_wrap = (r_fcnt == FCNT_LAST);
  assign vde_d     = r_vde_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vde_d    <= 1'b0;
      r_prev_row <= '0;
      r_fcnt     <= '0;
      frame_tick <= 1'b0;
      step       <= 1'b0;
    end else begin
      r_vde_d    <= vde;
      r_prev_row <= y;
      frame_tick <= frame_end;
      step       <= frame_end & fcnt_wrap;
      if (frame_end) begin
        r_fcnt <= fcnt_wrap ? '0 : r_fcnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/video_pattern_gen.sv
// Test-pattern generator with frame-aligned mode and animation.
// VIDEO_PATTERN_BOUNCE_EN selects a bouncing block instead of wrap.
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int COORD_W     = 10,
  parameter int COLOR_W     = 8,
  parameter int BLOCK_W     = 6,
  parameter int BLOCK_Y     = 230,
  parameter int CROSS_HALF  = 10,
  parameter int FRAME_DIV   = 256,
  parameter int STEP        = 1,
  parameter int CHECK_SHIFT = 5
) (
  input  logic               i_CLK,
  input  logic               i_RST_N,
  input  logic [2:0]         i_SEL,
  input  logic               i_VDE,
  input  logic [COORD_W-1:0] i_X_COORD,
  input  logic [COORD_W-1:0] i_Y_COORD,
  output logic [COLOR_W-1:0] o_RED,
  output logic [COLOR_W-1:0] o_GREEN,
  output logic [COLOR_W-1:0] o_BLUE,
  output logic               o_VDE,
  output logic               o_FRAME_TICK
);

  typedef logic [COORD_W-1:0] c_t;
  typedef logic [COORD_W:0]   cx_t;

  localparam c_t  H_MID     = c_t'(H_ACTIVE / 2);
  localparam c_t  V_MID     = c_t'(V_ACTIVE / 2);
  localparam c_t  HALF_W    = c_t'(CROSS_HALF);
  localparam c_t  SHIFT_MAX = c_t'(H_ACTIVE - BLOCK_W);
  localparam cx_t BAR_W     = cx_t'(H_ACTIVE / 8);
  localparam logic [COLOR_W-1:0] HALF =
    {1'b0, {(COLOR_W-1){1'b1}}};

  logic       frame_tick;
  logic       step;
  logic [2:0] r_mode;
  c_t         r_shift;
  c_t         shift_nxt;
  cx_t        sum;

  frame_tick_gen #(
    .V_ACTIVE  (V_ACTIVE),
    .COORD_W   (COORD_W),
    .FRAME_DIV (FRAME_DIV)
  ) u_tick (
    .clk        (i_CLK),
    .rst_n      (i_RST_N),
    .vde        (i_VDE),
    .y          (i_Y_COORD),
    .vde_d      (o_VDE),
    .frame_tick (frame_tick),
    .step       (step)
  );

  assign o_FRAME_TICK = frame_tick;
  assign sum = cx_t'(r_shift) + cx_t'(STEP);

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      r_mode  <= 3'd0;
      r_shift <= '0;
    end else begin
      if (frame_tick) r_mode <= i_SEL;
      r_shift <= shift_nxt;
    end
  end

`ifdef VIDEO_PATTERN_BOUNCE_EN
  dir_e r_dir;
  dir_e dir_nxt;

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) r_dir <= DIR_RIGHT;
    else          r_dir <= dir_nxt;
  end

  always_comb begin
    dir_nxt   = r_dir;
    shift_nxt = r_shift;
    if (step) begin
      unique case (r_dir)
        DIR_RIGHT: begin
          if (sum >= cx_t'(SHIFT_MAX)) begin
            shift_nxt = SHIFT_MAX;
            dir_nxt   = DIR_LEFT;
          end else begin
            shift_nxt = sum[COORD_W-1:0];
          end
        end
        DIR_LEFT: begin
          // Covers both landing on zero and underflow
          if (r_shift <= c_t'(STEP)) begin
            shift_nxt = '0;
            dir_nxt   = DIR_RIGHT;
          end else begin
            shift_nxt = r_shift - c_t'(STEP);
          end
        end
        default: ;
      endcase
    end
  end
`else
  always_comb begin
    shift_nxt = r_shift;
    if (step) begin
      shift_nxt = (sum > cx_t'(SHIFT_MAX)) ?
                  '0 : sum[COORD_W-1:0];
    end
  end
`endif

  c_t         dx;
  c_t         dy;
  logic       cross_hit;
  logic       blk_hit;
  logic       in_bars;
  logic [2:0] bar_idx;
  logic       chk_hit;
  logic [2:0] rgb_en;
  logic       solid;

  always_comb begin
    dx = (i_X_COORD >= H_MID) ?
         i_X_COORD - H_MID : H_MID - i_X_COORD;
    dy = (i_Y_COORD >= V_MID) ?
         i_Y_COORD - V_MID : V_MID - i_Y_COORD;
    cross_hit = (dx <= HALF_W) || (dy <= HALF_W);
    blk_hit =
      (i_X_COORD >= r_shift) &&
      (cx_t'(i_X_COORD) <
       cx_t'(r_shift) + cx_t'(BLOCK_W)) &&
      (cx_t'(i_Y_COORD) >= cx_t'(BLOCK_Y)) &&
      (cx_t'(i_Y_COORD) < cx_t'(BLOCK_Y + BLOCK_W));
    // Bar index by constant thresholds, no divider
    bar_idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (cx_t'(i_X_COORD) >= cx_t'(i) * BAR_W)
        bar_idx = 3'(i);
    end
    in_bars = cx_t'(i_X_COORD) < cx_t'(8) * BAR_W;
    chk_hit = i_X_COORD[CHECK_SHIFT] ^
              i_Y_COORD[CHECK_SHIFT];
  end

  always_comb begin
    rgb_en = 3'b000;
    solid  = 1'b0;
    unique case (1'b1)
      r_mode == MODE_SOLID:   solid  = 1'b1;
      r_mode == MODE_CROSS:   rgb_en = {cross_hit, 2'b00};
      r_mode == MODE_BLOCK:   rgb_en = {1'b0, blk_hit, 1'b0};
      r_mode == MODE_BARS:
        rgb_en = in_bars ? bar_rgb(bar_idx) : 3'b000;
      r_mode == MODE_CHECKER: rgb_en = {3{chk_hit}};
      default: ;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      o_RED   <= '0;
      o_GREEN <= '0;
      o_BLUE  <= '0;
    end else if (!i_VDE) begin
      o_RED   <= '0;
      o_GREEN <= '0;
      o_BLUE  <= '0;
    end else if (solid) begin
      o_RED   <= HALF;
      o_GREEN <= HALF;
      o_BLUE  <= HALF;
    end else begin
      o_RED   <= {COLOR_W{rgb_en[2]}};
      o_GREEN <= {COLOR_W{rgb_en[1]}};
      o_BLUE  <= {COLOR_W{rgb_en[0]}};
    end
  end

endmodule
